reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rises are the active edge.
REQ-002 SHALL have ports: rst  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have ports: flush  in  1  synchronous clear of all entries (pipeline stop).
REQ-004 SHALL have ports: alloc_valid  in  1  dispatch requests one entry this cycle.
REQ-005 SHALL have ports: alloc_areg  in  5 architectural destination register; alloc_tag_PRF  in  5  new physical tag; alloc_old_PRF  in  5  previous mapping of alloc_areg.
REQ-006 SHALL have ports: alloc_tag_ROB  out  4  index granted to the dispatching instruction; equals tail pointer, combinational.
REQ-007 SHALL have ports: full  out  1  and  empty  out  1, both combinational from occupancy.
REQ-008 SHALL have ports: valid_Result_add  in  1, tag_ROB_add  in  4, valid_Result_mul  in  1, tag_ROB_mul  in  4  completion broadcasts.
REQ-009 SHALL have ports: commit_stall  in  1  back-end freeze; blocks retirement.
REQ-010 SHALL have ports: commit_valid  out  1, commit_areg  out  5, commit_tag_PRF  out  5, commit_old_PRF  out  5  registered retirement to rename map/free list.

Function
REQ-011 SHALL hold 16 entries {valid, done, areg, tag_PRF, old_PRF}; head and tail 4-bit pointers wrapping 15->0; count 5-bit, 0..16.
REQ-012 SHALL assert full iff count==16 and empty iff count==0.
REQ-013 SHALL, when alloc_valid && !full, write entry[tail] with valid=1, done=0, payload from inputs, and increment tail at the edge; when full, the request SHALL be ignored with no state change.
REQ-014 SHALL, for each asserted broadcast whose entry is valid, set that entry's done=1 at the edge; broadcasts to invalid entries SHALL be ignored; add and mul naming the same index SHALL both set done.
REQ-015 SHALL retire at most one entry per cycle: if !commit_stall and entry[head] valid and done, register commit_valid=1 with its payload, clear the entry, increment head; otherwise register commit_valid=0 with commit_areg/commit_tag_PRF/commit_old_PRF=0.
REQ-016 SHALL retire strictly in allocation order; an entry that is done but not at head SHALL wait.
REQ-017 SHALL keep count unchanged on simultaneous allocate and retire; full SHALL reflect pre-edge count, so an allocation while full is rejected even when a retirement occurs in that cycle.
REQ-018 SHALL allow allocation into an empty buffer and a completion to a different index in the same cycle.
REQ-019 SHALL give flush priority over all other actions: at the edge clear all valid/done bits, head=tail=count=0, commit outputs 0.
REQ-020 SHALL have latency: broadcast sampled at edge N sets done; earliest commit_valid=1 is after edge N+1 (without Configuration feature).

Reset
REQ-021 SHALL, while rst=0, clear all entries, head=tail=0, count=0, commit_valid=0, commit_areg=commit_tag_PRF=commit_old_PRF=0; outputs thus full=0, empty=1, alloc_tag_ROB=0.
REQ-022 SHALL take effect immediately on rst falling, mid-operation included, discarding in-flight entries.

Configuration
REQ-023 SHALL provide macro ROB_COMPLETE_BYPASS_EN.
REQ-024 SHALL, with ROB_COMPLETE_BYPASS_EN defined, treat entry[head] as done when a valid broadcast names head in the same cycle, retiring it at edge N (commit_valid high after edge N).
REQ-025 SHALL, without ROB_COMPLETE_BYPASS_EN, use only the stored done bit (REQ-020 latency).

Verification
REQ-026 SHALL cover: reset, allocate 3 (areg 1,2,3; PRF 8,9,10) -> alloc_tag_ROB 0,1,2; count 3; empty=0.
REQ-027 SHALL cover: complete index 2 then 0 via add -> commit areg1/PRF8 next cycle; areg3 held until index1 completed via mul; then areg2, areg3 retire on consecutive cycles.
REQ-028 SHALL cover: allocate 16 -> full=1; 17th alloc ignored; complete head plus alloc same cycle -> after retire, alloc accepted at index 0 (wrap), count 16.
REQ-029 SHALL cover: commit_stall=1 with head done for 3 cycles -> commit_valid=0; release -> retires next edge.
REQ-030 SHALL cover: flush with 5 entries, 2 done -> next cycle empty=1, commit_valid=0, alloc_tag_ROB=0; rst low mid-run -> same immediately.
REQ-031 SHALL cover: broadcast to head at edge N -> commit_valid after edge N+1 without macro, after edge N with ROB_COMPLETE_BYPASS_EN.

Source files
------------

// File: rtl/reorder_buffer.sv
// 16-entry in-order retirement buffer: allocate at tail, mark done from add/mul broadcasts, retire from head.
// Optional macro ROB_COMPLETE_BYPASS_EN lets a same-cycle broadcast to head retire it at that edge.
module reorder_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       alloc_valid,
  input  logic [4:0] alloc_areg,
  input  logic [4:0] alloc_tag_PRF,
  input  logic [4:0] alloc_old_PRF,
  output logic [3:0] alloc_tag_ROB,
  output logic       full,
  output logic       empty,
  input  logic       valid_Result_add,
  input  logic [3:0] tag_ROB_add,
  input  logic       valid_Result_mul,
  input  logic [3:0] tag_ROB_mul,
  input  logic       commit_stall,
  output logic       commit_valid,
  output logic [4:0] commit_areg,
  output logic [4:0] commit_tag_PRF,
  output logic [4:0] commit_old_PRF
);

  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int REG_W = 5;

  logic [IDX_W-1:0] head_reg;
  logic [IDX_W-1:0] tail_reg;
  logic [IDX_W:0]   count_reg;
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] done_reg;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] done_next;
  logic [DEPTH-1:0] set_done;
  logic [REG_W-1:0] areg_mem    [DEPTH];
  logic [REG_W-1:0] tag_prf_mem [DEPTH];
  logic [REG_W-1:0] old_prf_mem [DEPTH];

  logic head_done;
  logic do_alloc;
  logic do_commit;

  assign full          = (count_reg == 5'd16);
  assign empty         = (count_reg == 5'd0);
  assign alloc_tag_ROB = tail_reg;

  // Broadcasts only count against entries that are live before the edge.
  always_comb begin
    set_done = '0;
    for (int i = 0; i < DEPTH; i++) begin
      set_done[i] = valid_reg[i] &&
                    ((valid_Result_add && (tag_ROB_add == IDX_W'(i))) ||
                     (valid_Result_mul && (tag_ROB_mul == IDX_W'(i))));
    end
  end

`ifdef ROB_COMPLETE_BYPASS_EN
  assign head_done = done_reg[head_reg] | set_done[head_reg];
`else
  assign head_done = done_reg[head_reg];
`endif

  // full is the pre-edge view, so a retirement never frees a slot for the same cycle.
  assign do_alloc  = alloc_valid && !full;
  assign do_commit = !commit_stall && valid_reg[head_reg] && head_done;

  always_comb begin
    valid_next = valid_reg;
    done_next  = done_reg | set_done;
    if (do_commit) begin
      valid_next[head_reg] = 1'b0;
      done_next[head_reg]  = 1'b0;
    end
    if (do_alloc) begin
      valid_next[tail_reg] = 1'b1;
      done_next[tail_reg]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      valid_reg      <= '0;
      done_reg       <= '0;
      commit_valid   <= 1'b0;
      commit_areg    <= '0;
      commit_tag_PRF <= '0;
      commit_old_PRF <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        areg_mem[i]    <= '0;
        tag_prf_mem[i] <= '0;
        old_prf_mem[i] <= '0;
      end
    end else if (flush) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      valid_reg      <= '0;
      done_reg       <= '0;
      commit_valid   <= 1'b0;
      commit_areg    <= '0;
      commit_tag_PRF <= '0;
      commit_old_PRF <= '0;
    end else begin
      valid_reg <= valid_next;
      done_reg  <= done_next;
      count_reg <= count_reg + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_commit);
      if (do_alloc) begin
        tail_reg              <= tail_reg + 1'b1;
        areg_mem[tail_reg]    <= alloc_areg;
        tag_prf_mem[tail_reg] <= alloc_tag_PRF;
        old_prf_mem[tail_reg] <= alloc_old_PRF;
      end
      if (do_commit) begin
        head_reg       <= head_reg + 1'b1;
        commit_valid   <= 1'b1;
        commit_areg    <= areg_mem[head_reg];
        commit_tag_PRF <= tag_prf_mem[head_reg];
        commit_old_PRF <= old_prf_mem[head_reg];
      end else begin
        commit_valid   <= 1'b0;
        commit_areg    <= '0;
        commit_tag_PRF <= '0;
        commit_old_PRF <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; expected latencies follow ROB_COMPLETE_BYPASS_EN when defined.
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       alloc_valid = 1'b0;
  logic [4:0] alloc_areg = '0;
  logic [4:0] alloc_tag_PRF = '0;
  logic [4:0] alloc_old_PRF = '0;
  logic [3:0] alloc_tag_ROB;
  logic       full;
  logic       empty;
  logic       valid_Result_add = 1'b0;
  logic [3:0] tag_ROB_add = '0;
  logic       valid_Result_mul = 1'b0;
  logic [3:0] tag_ROB_mul = '0;
  logic       commit_stall = 1'b0;
  logic       commit_valid;
  logic [4:0] commit_areg;
  logic [4:0] commit_tag_PRF;
  logic [4:0] commit_old_PRF;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_areg(alloc_areg),
    .alloc_tag_PRF(alloc_tag_PRF), .alloc_old_PRF(alloc_old_PRF),
    .alloc_tag_ROB(alloc_tag_ROB), .full(full), .empty(empty),
    .valid_Result_add(valid_Result_add), .tag_ROB_add(tag_ROB_add),
    .valid_Result_mul(valid_Result_mul), .tag_ROB_mul(tag_ROB_mul),
    .commit_stall(commit_stall), .commit_valid(commit_valid),
    .commit_areg(commit_areg), .commit_tag_PRF(commit_tag_PRF),
    .commit_old_PRF(commit_old_PRF)
  );

  // Advance one active edge and settle; one line per edge that retired something.
  task automatic step();
    @(posedge clk);
    #1;
    if (commit_valid === 1'b1)
      $display("  commit areg=%0d prf=%0d old=%0d", commit_areg, commit_tag_PRF, commit_old_PRF);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    $display("test_reset");
    #3;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", full); end
    checks++; if (alloc_tag_ROB !== 4'd0) begin errors++; $display("FAIL reset_tag got=%0d want=0", alloc_tag_ROB); end
    checks++; if (commit_valid !== 1'b0 || commit_areg !== 5'd0) begin errors++;
      $display("FAIL reset_commit got=%b/%0d want=0/0", commit_valid, commit_areg); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_alloc();
    $display("test_alloc");
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_areg = 5'(i + 1);
      alloc_tag_PRF = 5'(i + 8);
      alloc_old_PRF = 5'(i + 20);
      #1;
      checks++; if (alloc_tag_ROB !== 4'(i)) begin errors++; $display("FAIL alloc_tag got=%0d want=%0d", alloc_tag_ROB, i); end
      step();
    end
    alloc_valid = 1'b0;
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL alloc_empty got=%b want=0", empty); end
    checks++; if (alloc_tag_ROB !== 4'd3) begin errors++; $display("FAIL alloc_tail got=%0d want=3", alloc_tag_ROB); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL alloc_nocommit got=%b want=0", commit_valid); end
  endtask

  task automatic test_out_of_order();
    $display("test_out_of_order");
    valid_Result_add = 1'b1; tag_ROB_add = 4'd2;
    step();
    valid_Result_add = 1'b0;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_idx2_wait got=%b want=0", commit_valid); end
    valid_Result_add = 1'b1; tag_ROB_add = 4'd0;
    step();
    valid_Result_add = 1'b0;
`ifndef ROB_COMPLETE_BYPASS_EN
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_latency got=%b want=0", commit_valid); end
    step();
`endif
    checks++; if (commit_valid !== 1'b1 || commit_areg !== 5'd1 || commit_tag_PRF !== 5'd8 || commit_old_PRF !== 5'd20) begin
      errors++; $display("FAIL ooo_commit0 got=%b/%0d/%0d/%0d want=1/1/8/20",
                         commit_valid, commit_areg, commit_tag_PRF, commit_old_PRF); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_hold got=%b want=0", commit_valid); end
    end
    valid_Result_mul = 1'b1; tag_ROB_mul = 4'd1;
    step();
    valid_Result_mul = 1'b0;
`ifndef ROB_COMPLETE_BYPASS_EN
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_mul_latency got=%b want=0", commit_valid); end
    step();
`endif
    checks++; if (commit_valid !== 1'b1 || commit_areg !== 5'd2 || commit_tag_PRF !== 5'd9) begin
      errors++; $display("FAIL ooo_commit1 got=%b/%0d/%0d want=1/2/9", commit_valid, commit_areg, commit_tag_PRF); end
    step();
    checks++; if (commit_valid !== 1'b1 || commit_areg !== 5'd3 || commit_old_PRF !== 5'd22) begin
      errors++; $display("FAIL ooo_commit2 got=%b/%0d/%0d want=1/3/22", commit_valid, commit_areg, commit_old_PRF); end
    step();
    checks++; if (commit_valid !== 1'b0 || commit_areg !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL ooo_drained got=%b/%0d/%b want=0/0/1", commit_valid, commit_areg, empty); end
  endtask

  task automatic test_full_wrap();
    $display("test_full_wrap");
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1'b1;
      alloc_areg = 5'(i);
      alloc_tag_PRF = 5'(i + 8);
      alloc_old_PRF = 5'(i + 16);
      step();
    end
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL full_set got=%b/%b want=1/0", full, empty); end
    checks++; if (alloc_tag_ROB !== 4'd0) begin errors++; $display("FAIL full_tail_wrap got=%0d want=0", alloc_tag_ROB); end
    alloc_areg = 5'd31; alloc_tag_PRF = 5'd31; alloc_old_PRF = 5'd30;
    step();
    checks++; if (full !== 1'b1 || alloc_tag_ROB !== 4'd0) begin errors++;
      $display("FAIL full_reject got=%b/%0d want=1/0", full, alloc_tag_ROB); end
    valid_Result_add = 1'b1; tag_ROB_add = 4'd0;
    step();
    valid_Result_add = 1'b0;
`ifndef ROB_COMPLETE_BYPASS_EN
    checks++; if (commit_valid !== 1'b0 || full !== 1'b1) begin errors++;
      $display("FAIL full_done_wait got=%b/%b want=0/1", commit_valid, full); end
    step();
`endif
    checks++; if (commit_valid !== 1'b1 || commit_areg !== 5'd0 || commit_tag_PRF !== 5'd8 || commit_old_PRF !== 5'd16) begin
      errors++; $display("FAIL full_retire got=%b/%0d/%0d/%0d want=1/0/8/16",
                         commit_valid, commit_areg, commit_tag_PRF, commit_old_PRF); end
    checks++; if (full !== 1'b0 || alloc_tag_ROB !== 4'd0) begin errors++;
      $display("FAIL full_retire_alloc_rejected got=%b/%0d want=0/0", full, alloc_tag_ROB); end
    step();
    alloc_valid = 1'b0;
    checks++; if (full !== 1'b1 || alloc_tag_ROB !== 4'd1 || commit_valid !== 1'b0) begin errors++;
      $display("FAIL full_wrap_alloc got=%b/%0d/%b want=1/1/0", full, alloc_tag_ROB, commit_valid); end
  endtask

  task automatic test_stall();
    $display("test_stall");
    commit_stall = 1'b1;
    valid_Result_mul = 1'b1; tag_ROB_mul = 4'd1;
    step();
    valid_Result_mul = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got=%b want=0", i, commit_valid); end
      if (i < 2) step();
    end
    commit_stall = 1'b0;
    step();
    checks++; if (commit_valid !== 1'b1 || commit_areg !== 5'd1 || commit_tag_PRF !== 5'd9 || commit_old_PRF !== 5'd17) begin
      errors++; $display("FAIL stall_release got=%b/%0d/%0d/%0d want=1/1/9/17",
                         commit_valid, commit_areg, commit_tag_PRF, commit_old_PRF); end
    step();
    checks++; if (commit_valid !== 1'b0 || full !== 1'b0) begin errors++;
      $display("FAIL stall_after got=%b/%b want=0/0", commit_valid, full); end
  endtask

  task automatic test_flush();
    $display("test_flush");
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_areg = 5'(i + 1); alloc_tag_PRF = 5'(i + 10); alloc_old_PRF = 5'(i);
      step();
    end
    alloc_valid = 1'b0;
    valid_Result_add = 1'b1; tag_ROB_add = 4'd1;
    valid_Result_mul = 1'b1; tag_ROB_mul = 4'd3;
    step();
    valid_Result_mul = 1'b0;
    flush = 1'b1; tag_ROB_add = 4'd0; alloc_valid = 1'b1;
    step();
    flush = 1'b0; valid_Result_add = 1'b0; alloc_valid = 1'b0;
    checks++; if (empty !== 1'b1 || alloc_tag_ROB !== 4'd0 || commit_valid !== 1'b0) begin errors++;
      $display("FAIL flush_clear got=%b/%0d/%b want=1/0/0", empty, alloc_tag_ROB, commit_valid); end
    alloc_valid = 1'b1; alloc_areg = 5'd7;
    step();
    alloc_valid = 1'b0;
    step(); step();
    checks++; if (commit_valid !== 1'b0 || alloc_tag_ROB !== 4'd1) begin errors++;
      $display("FAIL flush_done_cleared got=%b/%0d want=0/1", commit_valid, alloc_tag_ROB); end
  endtask

  task automatic test_async_reset();
    $display("test_async_reset");
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_areg = 5'(i + 4); alloc_tag_PRF = 5'(i + 1); alloc_old_PRF = 5'(i + 2);
      step();
    end
    alloc_valid = 1'b0;
    valid_Result_add = 1'b1; tag_ROB_add = 4'd0;
    step();
    valid_Result_add = 1'b0;
`ifndef ROB_COMPLETE_BYPASS_EN
    step();
`endif
    checks++; if (commit_valid !== 1'b1 || commit_areg !== 5'd4) begin errors++;
      $display("FAIL arst_precommit got=%b/%0d want=1/4", commit_valid, commit_areg); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (commit_valid !== 1'b0 || commit_areg !== 5'd0 || empty !== 1'b1 || alloc_tag_ROB !== 4'd0 || full !== 1'b0) begin
      errors++; $display("FAIL arst_immediate got=%b/%0d/%b/%0d/%b want=0/0/1/0/0",
                         commit_valid, commit_areg, empty, alloc_tag_ROB, full); end
    rst = 1'b1;
  endtask

  task automatic test_latency();
    $display("test_latency");
    apply_reset();
    alloc_valid = 1'b1; alloc_areg = 5'd9; alloc_tag_PRF = 5'd19; alloc_old_PRF = 5'd29;
    step();
    alloc_valid = 1'b0;
    valid_Result_add = 1'b1; tag_ROB_add = 4'd0;
    step();
    valid_Result_add = 1'b0;
`ifdef ROB_COMPLETE_BYPASS_EN
    checks++; if (commit_valid !== 1'b1 || commit_areg !== 5'd9) begin errors++;
      $display("FAIL lat_bypass_edgeN got=%b/%0d want=1/9", commit_valid, commit_areg); end
`else
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL lat_edgeN got=%b want=0", commit_valid); end
    step();
    checks++; if (commit_valid !== 1'b1 || commit_areg !== 5'd9 || commit_tag_PRF !== 5'd19) begin errors++;
      $display("FAIL lat_edgeN1 got=%b/%0d/%0d want=1/9/19", commit_valid, commit_areg, commit_tag_PRF); end
`endif
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lat_empty got=%b want=1", empty); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_out_of_order();
    test_full_wrap();
    test_stall();
    test_flush();
    test_async_reset();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
